// File: rtl/y86_alu_pkg.sv
// y86_alu_pkg: shared ALU function codes, condition-code bit positions and FSM states
package y86_alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_slice.sv
// alu_slice: one SLICE_W-bit step of the serial ALU with carry in/out
module alu_slice
  import y86_alu_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic [3:0]         ifun,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] r,
  output logic               cout
);
  logic [SLICE_W:0] w_sum;
  // SUB reuses the adder with A inverted; the caller seeds cin=1 on the first slice
  always_comb begin
    w_sum = {1'b0, b} + {1'b0, (ifun == ALU_SUB) ? ~a : a} + {{SLICE_W{1'b0}}, cin};
    r     = (ifun == ALU_AND) ? (a & b) : (ifun == ALU_XOR) ? (a ^ b) : w_sum[SLICE_W-1:0];
    cout  = w_sum[SLICE_W];
  end
endmodule

// File: rtl/alu_serial_responder.sv
// alu_serial_responder: valid/ready ALU responder computing ADD/SUB/AND/XOR one slice per cycle
module alu_serial_responder
  import y86_alu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_ifun,
  input  logic [DATA_W-1:0] req_vala,
  input  logic [DATA_W-1:0] req_valb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_vale,
  output logic [2:0]        resp_cc,
  output logic              resp_err
);
  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int M      = DATA_W - 1;
  state_t              r_state, w_next;
  logic [3:0]          r_ifun;
  logic [DATA_W-1:0]   r_a, r_b, r_res, w_res;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_carry, r_err;
  logic [2:0]          r_cc, w_cc;
  logic [SLICE_W-1:0]  w_sa, w_sb, w_sr;
  logic                w_cout, w_last, w_legal;

  alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .ifun(r_ifun), .a(w_sa), .b(w_sb), .cin(r_carry), .r(w_sr), .cout(w_cout)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  // next state: illegal codes skip CALC, DONE waits for the consumer
  always_comb begin
    w_legal = req_ifun[3:2] == 2'b00;
    w_last  = r_cnt == CNT_W'(NSLICE - 1);
    w_next  = r_state;
    w_next  = (r_state == ST_IDLE) ? (req_valid ? (w_legal ? ST_CALC : ST_DONE) : ST_IDLE) :
              (r_state == ST_CALC) ? (w_last ? ST_DONE : ST_CALC) :
              (resp_ready ? ST_IDLE : ST_DONE);
  end

  // current slice operands, merged result and condition codes from the full result
  always_comb begin
    w_sa = r_a[r_cnt*SLICE_W +: SLICE_W];
    w_sb = r_b[r_cnt*SLICE_W +: SLICE_W];
    w_res = r_res;
    w_res[r_cnt*SLICE_W +: SLICE_W] = w_sr;
    w_cc = '0;
    w_cc[ZF] = w_res == '0;
    w_cc[SF] = w_res[M];
    w_cc[OF] = (r_ifun == ALU_ADD) ? (r_a[M] == r_b[M]) && (w_res[M] != r_a[M]) :
               (r_ifun == ALU_SUB) ? (r_a[M] != r_b[M]) && (w_res[M] != r_b[M]) : 1'b0;
  end

  // datapath: latch request, accumulate slices, publish result and CC on the last slice
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifun  <= ALU_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cc    <= 3'b100;
      r_err   <= 1'b0;
    end else if (r_state == ST_IDLE && req_valid) begin
      r_ifun  <= req_ifun;
      r_a     <= req_vala;
      r_b     <= req_valb;
      r_cnt   <= '0;
      r_carry <= req_ifun == ALU_SUB;
      r_err   <= !w_legal;
      if (!w_legal) r_res <= '0;
    end else if (r_state == ST_CALC) begin
      r_res   <= w_res;
      r_carry <= w_cout;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) r_cc <= w_cc;
    end
  end

  assign req_ready  = r_state == ST_IDLE;
  assign resp_valid = r_state == ST_DONE;
  assign resp_vale  = r_res;
  assign resp_cc    = r_cc;
  assign resp_err   = r_err;
endmodule

// File: tb/tb_alu_serial_responder.sv
// tb_alu_serial_responder: directed and random checks against a whole-word arithmetic model
module tb_alu_serial_responder;
  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, resp_ready = 1'b0;
  logic [3:0]  req_ifun = 4'h0;
  logic [63:0] req_vala = '0, req_valb = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_vale;
  logic [2:0]  resp_cc;
  int          n_checks = 0, n_fails = 0;
  logic [2:0]  m_cc = 3'b100;

  alu_serial_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ifun(req_ifun), .req_vala(req_vala), .req_valb(req_valb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vale(resp_vale),
    .resp_cc(resp_cc), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: whole-word arithmetic, Y86 condition-code rules
  task automatic model(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] v, output logic [2:0] cc, output logic e);
    logic of;
    e = 1'b0;
    of = 1'b0;
    case (f)
      4'h0: begin v = b + a; of = (a[63] == b[63]) && (v[63] != a[63]); end
      4'h1: begin v = b - a; of = (a[63] != b[63]) && (v[63] != b[63]); end
      4'h2: v = a & b;
      4'h3: v = a ^ b;
      default: begin v = '0; e = 1'b1; end
    endcase
    cc = e ? m_cc : {v == 64'h0, v[63], of};
  endtask

  task automatic run_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                        input int hold, input bit poke);
    logic [63:0] ev;
    logic [2:0]  ecc;
    logic        ee;
    int          n;
    model(f, a, b, ev, ecc, ee);
    @(negedge clk);
    check("ready_before", req_ready, 1);
    req_valid = 1'b1; req_ifun = f; req_vala = a; req_valb = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      check("busy_ready", req_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, ee ? 0 : 4);
    check("vale", resp_vale, ev);
    check("cc", resp_cc, ecc);
    check("err", resp_err, ee);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid = 1'b1; req_ifun = 4'h0; req_vala = $urandom; req_valb = $urandom;
      end
      @(posedge clk); #1;
      check("hold_valid", resp_valid, 1);
      check("hold_ready", req_ready, 0);
      check("hold_vale", resp_vale, ev);
      check("hold_cc", resp_cc, ecc);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("after_valid", resp_valid, 0);
    check("after_ready", req_ready, 1);
    check("after_vale", resp_vale, ev);
    check("after_cc", resp_cc, ecc);
    req_valid = 1'b0;
    m_cc = ecc;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_valid", resp_valid, 0);
    check("rst_vale", resp_vale, 0);
    check("rst_cc", resp_cc, 3'b100);
    check("rst_err", resp_err, 0);
    run_op(4'h3, 64'hAA55AA55AA55AA55, 64'h55AA55AA55AA55AA, 0, 0);
    run_op(4'h0, 64'h1, 64'h7FFFFFFFFFFFFFFF, 0, 0);
    run_op(4'h0, 64'h1, 64'h000000000000FFFF, 1, 0);
    run_op(4'h1, 64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF, 0, 0);
    run_op(4'h1, 64'h1, 64'h8000000000000000, 0, 0);
    run_op(4'h2, 64'hFFFF0000FFFF0000, 64'hFFFFFFFF00000000, 5, 1);
    run_op(4'h7, 64'h1234, 64'h5678, 2, 0);
    run_op(4'hF, 64'h0, 64'h0, 0, 0);
    // abort mid-CALC
    @(negedge clk);
    req_valid = 1'b1; req_ifun = 4'h0; req_vala = 64'h5; req_valb = 64'h5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_busy", req_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cc = 3'b100;
    check("abort_ready", req_ready, 1);
    check("abort_valid", resp_valid, 0);
    check("abort_cc", resp_cc, 3'b100);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_resp", resp_valid, 0);
    end
    run_op(4'h3, 64'h1, 64'h0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 8 == 1) b = a;
      if (i % 8 == 2) a = 64'h8000000000000000;
      run_op(4'($urandom_range(0, 5)), a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
